mips_mc_controller: RTL and testbench
=====================================

// Module: mips_mc_controller
// PURPOSE
//  Main control FSM and ALU decoder for the multicycle MIPS core. Consumes OP, Funct and Zero from the
//  datapath; drives every datapath control input plus MemWrite to memory. Supports lw, sw, R-type
//  (add/sub/and/or/slt), beq, addi and j. One instruction at a time, no overlap between instructions.
// PARAMETERS
//  ILLEGAL_HALT  0  0: an illegal instruction pulses illegal and returns to FETCH; 1: the FSM parks in HALT until reset
// PORTS
//  clk         in   1  clock; every transition occurs on the rising edge
//  reset_n     in   1  asynchronous, active-low reset
//  OP          in   6  Instr[31:26]
//  Funct       in   6  Instr[5:0]
//  Zero        in   1  ALU zero flag
//  PCEn        out  1  PC register enable = PCWrite | (Branch & Zero)
//  IRWrite     out  1  instruction register enable
//  RegWrite    out  1  register file write enable
//  MemWrite    out  1  data memory write enable
//  IorD        out  1  address mux select: 0=PC, 1=ALUOut
//  ALUSrcA     out  1  ALU A select: 0=PC, 1=A
//  ALUSrcB     out  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
//  MemtoReg    out  1  WD3 select: 0=ALUOut, 1=Data
//  RegDst      out  1  A3 select: 0=rt, 1=rd
//  PCSrc       out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
//  ALUControl  out  3  010=add, 110=sub, 000=and, 001=or, 111=slt
//  illegal     out  1  one-cycle pulse when DECODE sees an unsupported OP or Funct
//  state_dbg   out  4  current state encoding
// BEHAVIOUR
//  - The state register is 4 bits. While reset_n is low the state is held at FETCH(0) asynchronously.
//    Outputs are Moore-decoded from the state only; PCEn is the one exception and also uses Zero.
//  - Any control output not listed for a state is 0 in that state.
//  - Reset values: the outputs are the FETCH values. IRWrite=1, PCEn=1, ALUSrcB=01, ALUControl=010,
//    and all other outputs are 0. This is harmless because the datapath registers are also held in reset.
//  - States, their asserted outputs, and next state:
//    FETCH(0): IRWrite, PCWrite, ALUSrcB=01, add -> DECODE
//    DECODE(1): ALUSrcB=11, add (branch target into ALUOut). Next state by OP:
//      lw/sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; addi -> ADDIEX; j -> JUMP
//    MEMADR(2): ALUSrcA=1, ALUSrcB=10, add -> MEMRD if OP=lw, else MEMWR
//    MEMRD(3): IorD=1 -> MEMWB
//    MEMWB(4): MemtoReg=1, RegDst=0, RegWrite -> FETCH
//    MEMWR(5): IorD=1, MemWrite -> FETCH
//    EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUControl from Funct -> ALUWB
//    ALUWB(7): RegDst=1, RegWrite -> FETCH
//    BRANCH(8): ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch -> FETCH
//    ADDIEX(9): ALUSrcA=1, ALUSrcB=10, add -> ADDIWB
//    ADDIWB(10): RegDst=0, RegWrite -> FETCH
//    JUMP(11): PCSrc=10, PCWrite -> FETCH
//    HALT(12): all outputs 0 (including PCEn and IRWrite) -> HALT
//    Encodings 13-15 -> FETCH, with illegal not asserted.
//  - Opcodes: lw=6'h23, sw=6'h2B, R-type=6'h00, beq=6'h04, addi=6'h08, j=6'h02.
//    Funct codes: add=6'h20, sub=6'h22, and=6'h24, or=6'h25, slt=6'h2A.
//  - Illegal instruction: an unknown OP, or OP=0 with an unknown Funct, detected in DECODE.
//    illegal is asserted for that DECODE cycle only, and no register or memory write occurs.
//    Next state is FETCH when ILLEGAL_HALT=0, or HALT when ILLEGAL_HALT=1.
//  - Latency in cycles, counting FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
//  - PCEn in BRANCH follows Zero combinationally within the same cycle. Zero is ignored in every other state.
//  - A reset_n assertion in any state, including HALT, returns the FSM to FETCH immediately.
//    An instruction interrupted by reset is abandoned. A write is never split: write enables are single-state pulses.
// TESTING
//  1. Release reset with OP=6'h23 (lw) -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
//  2. OP=6'h2B (sw) -> states 0,1,2,5,0; MemWrite=1 for exactly one cycle with IorD=1; RegWrite never asserted.
//  3. OP=0 with Funct=6'h22, then Funct=6'h2A -> EXECUTE shows ALUControl=110, then 111; ALUWB shows RegDst=1.
//  4. beq with Zero=1 in BRANCH -> PCEn=1, PCSrc=01. beq with Zero=0 -> PCEn=0. Both return to FETCH after 3 cycles.
//  5. OP=6'h3F with ILLEGAL_HALT=0 -> illegal pulses 1 cycle in DECODE, then FETCH.
//     Same stimulus with ILLEGAL_HALT=1 -> state_dbg=12 with all outputs 0 until reset_n is low.
//  6. Drop reset_n during MEMWR, asynchronously and mid-cycle -> state_dbg=0 immediately and MemWrite=0 immediately.
//     j (6'h02) after release -> states 0,1,11 with PCSrc=10 and PCEn=1.

Source files
------------

// File: rtl/mips_mc_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mips_mc_controller
//
// Main control FSM and ALU decoder of the multicycle MIPS core. It steps one
// instruction at a time through FETCH, DECODE and the per-class execution
// states. Every datapath control is Moore-decoded from the state register.
// The only exception is PCEn, which also folds in the ALU Zero flag for beq.
//
// Supported instructions: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.
// DECODE flags an unknown opcode, or an R-type with an unknown funct, on
// `illegal` for exactly one cycle. The FSM then returns to FETCH, or parks in
// HALT when ILLEGAL_HALT=1. No write enable is raised for that instruction.
//
// Parameters
//   ILLEGAL_HALT  0: illegal -> FETCH, 1: illegal -> HALT until reset
//
// Ports
//   clk         in   1  rising-edge clock
//   reset_n     in   1  asynchronous active-low reset (state -> FETCH)
//   OP          in   6  Instr[31:26]
//   Funct       in   6  Instr[5:0]
//   Zero        in   1  ALU zero flag (only used in BRANCH)
//   PCEn        out  1  PC enable = PCWrite | (Branch & Zero)
//   IRWrite     out  1  instruction register enable
//   RegWrite    out  1  register file write enable
//   MemWrite    out  1  data memory write enable
//   IorD        out  1  memory address select: 0=PC, 1=ALUOut
//   ALUSrcA     out  1  ALU A select: 0=PC, 1=A
//   ALUSrcB     out  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
//   MemtoReg    out  1  register write data select: 0=ALUOut, 1=Data
//   RegDst      out  1  register write address select: 0=rt, 1=rd
//   PCSrc       out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
//   ALUControl  out  3  010=add, 110=sub, 000=and, 001=or, 111=slt
//   illegal     out  1  one-cycle pulse in DECODE on an unsupported instruction
//   state_dbg   out  4  current state encoding
// -----------------------------------------------------------------------------
module mips_mc_controller #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  // State encodings (visible on state_dbg)
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_HALT    = 4'd12;

  // Opcodes
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic       w_op_known;
  logic       w_funct_known;
  logic       w_instr_legal;
  logic [2:0] w_funct_alu;
  logic       w_pcwrite;
  logic       w_branch;

  // ---------------------------------------------------------------------------
  // Instruction legality and R-type ALU decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_funct_known = 1'b1;
    w_funct_alu   = ALU_ADD;
    case (Funct)
      FN_ADD:  w_funct_alu = ALU_ADD;
      FN_SUB:  w_funct_alu = ALU_SUB;
      FN_AND:  w_funct_alu = ALU_AND;
      FN_OR:   w_funct_alu = ALU_OR;
      FN_SLT:  w_funct_alu = ALU_SLT;
      default: w_funct_known = 1'b0;
    endcase
  end

  always_comb begin
    case (OP)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: w_op_known = 1'b1;
      default:                                       w_op_known = 1'b0;
    endcase
  end

  // Funct only matters for R-type; other formats reuse those bits as immediate.
  assign w_instr_legal = w_op_known && ((OP != OP_RTYPE) || w_funct_known);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        if (!w_instr_legal) begin
          w_next_state = ILLEGAL_HALT ? S_HALT : S_FETCH;
        end else begin
          case (OP)
            OP_LW, OP_SW: w_next_state = S_MEMADR;
            OP_RTYPE:     w_next_state = S_EXECUTE;
            OP_BEQ:       w_next_state = S_BRANCH;
            OP_ADDI:      w_next_state = S_ADDIEX;
            OP_J:         w_next_state = S_JUMP;
            default:      w_next_state = S_FETCH;
          endcase
        end
      end
      S_MEMADR:  w_next_state = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next_state = S_MEMWB;
      S_MEMWB:   w_next_state = S_FETCH;
      S_MEMWR:   w_next_state = S_FETCH;
      S_EXECUTE: w_next_state = S_ALUWB;
      S_ALUWB:   w_next_state = S_FETCH;
      S_BRANCH:  w_next_state = S_FETCH;
      S_ADDIEX:  w_next_state = S_ADDIWB;
      S_ADDIWB:  w_next_state = S_FETCH;
      S_JUMP:    w_next_state = S_FETCH;
      S_HALT:    w_next_state = S_HALT;
      // Unused encodings recover to FETCH without flagging illegal.
      default:   w_next_state = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    PCSrc      = 2'b00;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        w_pcwrite = 1'b1;
        ALUSrcB   = 2'b01;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcB = 2'b11;
        illegal = !w_instr_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = w_funct_alu;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        w_branch   = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_HALT: begin
        // Everything, including the add default, is forced low while parked.
        ALUControl = 3'b000;
      end
      default: begin
        ALUControl = 3'b000;
      end
    endcase
  end

  // Zero passes straight through so beq resolves within the BRANCH cycle.
  assign PCEn      = w_pcwrite | (w_branch & Zero);
  assign state_dbg = r_state;

endmodule

// File: tb/tb_mips_mc_controller.sv
`timescale 1ns/1ps
module tb_mips_mc_controller;

  typedef struct packed {
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [2:0] aluctl;
    logic       illegal;
    logic [3:0] st;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       Zero;

  outs_t dut_o [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: illegal returns to FETCH. Instance 1: illegal parks in HALT.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic       pcen, irwrite, regwrite, memwrite, iord, alusrca, memtoreg, regdst, ill;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluctl;
    logic [3:0] st;
    mips_mc_controller #(.ILLEGAL_HALT(gi == 1)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .OP         (OP),
      .Funct      (Funct),
      .Zero       (Zero),
      .PCEn       (pcen),
      .IRWrite    (irwrite),
      .RegWrite   (regwrite),
      .MemWrite   (memwrite),
      .IorD       (iord),
      .ALUSrcA    (alusrca),
      .ALUSrcB    (alusrcb),
      .MemtoReg   (memtoreg),
      .RegDst     (regdst),
      .PCSrc      (pcsrc),
      .ALUControl (aluctl),
      .illegal    (ill),
      .state_dbg  (st)
    );
    assign dut_o[gi] = {pcen, irwrite, regwrite, memwrite, iord, alusrca, alusrcb,
                        memtoreg, regdst, pcsrc, aluctl, ill, st};
  end

  // ---------------------------------------------------------------------------
  // Reference model: instruction classes map to a route of states after FETCH
  // (one nibble per cycle, F = back to FETCH); outputs come from a state table.
  // ---------------------------------------------------------------------------
  function automatic bit op_known(input logic [5:0] op);
    return op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
  endfunction

  function automatic bit fn_known(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  endfunction

  function automatic bit instr_ok(input logic [5:0] op, input logic [5:0] fn);
    return op_known(op) && (op != 6'h00 || fn_known(fn));
  endfunction

  function automatic logic [23:0] route(input logic [5:0] op, input logic [5:0] fn, input bit halt);
    if (!instr_ok(op, fn)) return halt ? 24'h1CFFFF : 24'h1FFFFF;
    case (op)
      6'h23:   return 24'h1234FF;  // lw:   5 cycles with FETCH
      6'h2B:   return 24'h125FFF;  // sw:   4
      6'h00:   return 24'h167FFF;  // R:    4
      6'h04:   return 24'h18FFFF;  // beq:  3
      6'h08:   return 24'h19AFFF;  // addi: 4
      default: return 24'h1BFFFF;  // j:    3
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic outs_t model_out(input int st, input logic [5:0] op, input logic [5:0] fn, input logic z);
    outs_t o;
    o = '0;
    o.st = 4'(st);
    o.aluctl = 3'b010;
    case (st)
      0:  begin o.irwrite = 1; o.pcen = 1; o.alusrcb = 2'b01; end
      1:  begin o.alusrcb = 2'b11; o.illegal = !instr_ok(op, fn); end
      2:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      3:  o.iord = 1;
      4:  begin o.memtoreg = 1; o.regwrite = 1; end
      5:  begin o.iord = 1; o.memwrite = 1; end
      6:  begin o.alusrca = 1; o.aluctl = alu_of(fn); end
      7:  begin o.regdst = 1; o.regwrite = 1; end
      8:  begin o.alusrca = 1; o.aluctl = 3'b110; o.pcsrc = 2'b01; o.pcen = z; end
      9:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      10: o.regwrite = 1;
      11: begin o.pcsrc = 2'b10; o.pcen = 1; end
      default: o.aluctl = 3'b000;  // HALT: every control low
    endcase
    return o;
  endfunction

  int          cur [2] = '{0, 0};
  int          k   [2] = '{0, 0};
  logic [23:0] rt  [2];

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      for (int h = 0; h < 2; h++) begin
        logic [23:0] r;
        logic [3:0]  nib;
        if (!reset_n) begin
          cur[h] = 0;
        end else if (cur[h] == 0) begin
          r      = route(OP, Funct, h == 1);
          rt[h]  = r;
          k[h]   = 0;
          cur[h] = int'(r[23:20]);
        end else if (cur[h] != 12) begin
          k[h]   = k[h] + 1;
          nib    = rt[h][23 - 4*k[h] -: 4];
          cur[h] = (nib == 4'hF) ? 0 : int'(nib);
        end
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int h = 0; h < 2; h++) begin
        outs_t e;
        e = model_out(cur[h], OP, Funct, Zero);
        checks++;
        if (dut_o[h] !== e) begin
          errors++;
          $display("FAIL cycle_cmp dut%0d t=%0t: actual=%05h required=%05h (model state %0d)",
                   h, $time, dut_o[h], e, cur[h]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed literal checks and random stimulus
  // ---------------------------------------------------------------------------
  outs_t cap [2][8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Samples n cycles starting with the current one (caller is at posedge+2).
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap[0][i] = dut_o[0];
      cap[1][i] = dut_o[1];
      if (i < n - 1) begin
        @(posedge clk);
        #2;
      end
    end
  endtask

  function automatic logic [31:0] seq_of(input int h, input int n);
    logic [31:0] a;
    a = '0;
    for (int i = 0; i < n; i++) a = (a << 4) | 32'(cap[h][i].st);
    return a;
  endfunction

  task automatic pick_instr();
    logic [5:0] v;
    case ($urandom_range(0, 9))
      0: begin OP = 6'h23; Funct = 6'($urandom_range(0, 63)); end
      1: begin OP = 6'h2B; Funct = 6'($urandom_range(0, 63)); end
      2, 3, 9: begin
        OP = 6'h00;
        case ($urandom_range(0, 4))
          0: Funct = 6'h20;
          1: Funct = 6'h22;
          2: Funct = 6'h24;
          3: Funct = 6'h25;
          default: Funct = 6'h2A;
        endcase
      end
      4: begin OP = 6'h04; Funct = 6'($urandom_range(0, 63)); end
      5: begin OP = 6'h08; Funct = 6'($urandom_range(0, 63)); end
      6: begin OP = 6'h02; Funct = 6'($urandom_range(0, 63)); end
      7: begin
        do v = 6'($urandom_range(0, 63)); while (op_known(v));
        OP = v; Funct = 6'($urandom_range(0, 63));
      end
      default: begin
        do v = 6'($urandom_range(0, 63)); while (fn_known(v));
        OP = 6'h00; Funct = v;
      end
    endcase
  endtask

  initial begin
    outs_t rv;
    reset_n = 1'b0;
    OP      = 6'h23;
    Funct   = 6'h00;
    Zero    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rv = '0; rv.pcen = 1; rv.irwrite = 1; rv.alusrcb = 2'b01; rv.aluctl = 3'b010;
    chk("reset_outs_dut0", 32'(dut_o[0]), 32'(rv));
    chk("reset_outs_dut1", 32'(dut_o[1]), 32'(rv));
    reset_n = 1'b1;

    // lw
    capture(6);
    chk("lw_states", seq_of(0, 6), 32'h012340);
    chk("lw_wb_regwrite_memtoreg", 32'({cap[0][4].regwrite, cap[0][4].memtoreg}), 32'h3);
    chk("lw_regwrite_elsewhere", 32'(cap[0][0].regwrite | cap[0][1].regwrite | cap[0][2].regwrite
                                    | cap[0][3].regwrite | cap[0][5].regwrite), 32'h0);
    // sw
    OP = 6'h2B;
    capture(5);
    chk("sw_states", seq_of(0, 5), 32'h01250);
    chk("sw_memwrite_iord", 32'({cap[0][3].memwrite, cap[0][3].iord}), 32'h3);
    chk("sw_memwrite_elsewhere", 32'(cap[0][0].memwrite | cap[0][1].memwrite | cap[0][2].memwrite
                                     | cap[0][4].memwrite), 32'h0);
    // R-type sub then slt
    OP = 6'h00; Funct = 6'h22;
    capture(5);
    chk("sub_states", seq_of(0, 5), 32'h01670);
    chk("sub_aluctl", 32'(cap[0][2].aluctl), 32'h6);
    chk("sub_wb_regdst", 32'({cap[0][3].regdst, cap[0][3].regwrite}), 32'h3);
    Funct = 6'h2A;
    capture(5);
    chk("slt_aluctl", 32'(cap[0][2].aluctl), 32'h7);
    // beq taken / not taken
    OP = 6'h04; Funct = 6'h00; Zero = 1'b1;
    capture(4);
    chk("beq_z1_states", seq_of(0, 4), 32'h0180);
    chk("beq_z1_pcen_pcsrc", 32'({cap[0][2].pcen, cap[0][2].pcsrc}), 32'h5);
    Zero = 1'b0;
    capture(4);
    chk("beq_z0_states", seq_of(0, 4), 32'h0180);
    chk("beq_z0_pcen", 32'(cap[0][2].pcen), 32'h0);
    // illegal opcode
    OP = 6'h3F;
    capture(3);
    chk("ill_states_dut0", seq_of(0, 3), 32'h010);
    chk("ill_pulse_dut0", 32'({cap[0][0].illegal, cap[0][1].illegal, cap[0][2].illegal}), 32'h2);
    chk("ill_states_dut1", seq_of(1, 3), 32'h01C);
    chk("halt_outs_dut1", 32'(cap[1][2]), 32'h0000C);
    // sw interrupted by reset during MEMWR
    OP = 6'h2B;
    capture(4);
    chk("sw2_states", seq_of(0, 4), 32'h0125);
    chk("sw2_memwr_active", 32'({cap[0][3].memwrite, cap[0][3].iord}), 32'h3);
    chk("halt_still_dut1", 32'(cap[1][3]), 32'h0000C);
    reset_n = 1'b0;
    #1;
    chk("async_rst_state_dut0", 32'(dut_o[0].st), 32'h0);
    chk("async_rst_memwrite_dut0", 32'(dut_o[0].memwrite), 32'h0);
    chk("async_rst_state_dut1", 32'(dut_o[1].st), 32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    // j
    OP = 6'h02;
    capture(4);
    chk("j_states", seq_of(0, 4), 32'h01B0);
    chk("j_pcen_pcsrc", 32'({cap[0][2].pcen, cap[0][2].pcsrc}), 32'h6);

    // Random phase; the falling-edge compare process checks every cycle.
    for (int it = 0; it < 3000; it++) begin
      @(posedge clk);
      #2;
      Zero = 1'($urandom_range(0, 1));
      if (!reset_n) begin
        reset_n = 1'b1;
        pick_instr();
      end else if ($urandom_range(0, 39) == 0 || (cur[1] == 12 && $urandom_range(0, 3) == 0)) begin
        reset_n = 1'b0;
        #1;
        for (int h = 0; h < 2; h++) begin
          checks++;
          if (dut_o[h].st !== 4'd0 || dut_o[h].memwrite !== 1'b0 || dut_o[h].regwrite !== 1'b0) begin
            errors++;
            $display("FAIL rand_async_rst dut%0d: actual st=%0d mw=%b rw=%b required st=0 mw=0 rw=0",
                     h, dut_o[h].st, dut_o[h].memwrite, dut_o[h].regwrite);
          end
        end
      end else if (cur[0] == 0) begin
        pick_instr();
      end
    end

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
